// File: rtl/cdb_pkg.sv
// Shared parameters, source indices and broadcast record for the CDB arbiter.
package cdb_pkg;

  localparam int NUM_SRC = 6;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int SRC_W   = 3;

  localparam logic [SRC_W-1:0] SRC_ADD1 = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ADD2 = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ADD3 = 3'd2;
  localparam logic [SRC_W-1:0] SRC_MUL1 = 3'd3;
  localparam logic [SRC_W-1:0] SRC_MUL2 = 3'd4;
  localparam logic [SRC_W-1:0] SRC_LS   = 3'd5;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Combinational round-robin arbiter: double-width masked priority encode
// starting at ptr and wrapping back to index 0.
module rr_arbiter
  import cdb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  localparam int DW = 2 * NUM_SRC;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] mask;
  logic [DW-1:0] masked;

  always_comb begin
    dbl_req = {req, req};
    mask    = '0;
    for (int k = 0; k < DW; k++) mask[k] = (k >= int'(ptr));
    masked  = dbl_req & mask;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Scan downward so the lowest set bit at or above ptr is the last one written.
    for (int k = DW - 1; k >= 0; k--) begin
      if (masked[k]) begin
        gnt_idx = SRC_W'(k % NUM_SRC);
        gnt_any = 1'b1;
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per producer, round-robin
// grant of one held result per cycle, registered broadcast.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [SRC_W:0]            pending_cnt
);

  logic [NUM_SRC-1:0] held_q, held_d;
  logic [DATA_W-1:0]  data_q [NUM_SRC];
  logic [DATA_W-1:0]  data_d [NUM_SRC];
  logic [TAG_W-1:0]   tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   tag_d  [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W:0]     pending_q, pending_d;
  cdb_bus_t           cdb_q, cdb_d;

  logic [NUM_SRC-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_SRC-1:0] accept;

  rr_arbiter u_rr (
    .req     (held_q),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign src_ready = ~held_q | gnt;
  assign accept    = src_valid & src_ready;

  always_comb begin
    held_d    = (held_q & ~gnt) | accept;
    rr_ptr_d  = rr_ptr_q;
    cdb_d     = cdb_q;
    cdb_d.valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      data_d[i] = accept[i] ? src_data[i*DATA_W +: DATA_W] : data_q[i];
      tag_d[i]  = accept[i] ? src_tag[i*TAG_W +: TAG_W]    : tag_q[i];
    end
    if (gnt_any) begin
      cdb_d.valid = 1'b1;
      cdb_d.data  = data_q[gnt_idx];
      cdb_d.tag   = tag_q[gnt_idx];
      cdb_d.src   = gnt_idx;
      rr_ptr_d    = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
    // Flush overrides both the capture and the broadcast of this cycle.
    if (flush) begin
      held_d      = '0;
      rr_ptr_d    = '0;
      cdb_d.valid = 1'b0;
    end
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) pending_d = pending_d + {{SRC_W{1'b0}}, held_d[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      cdb_q     <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      held_q    <= held_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      cdb_q     <= cdb_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_data    = cdb_q.data;
  assign cdb_tag     = cdb_q.tag;
  assign cdb_src     = cdb_q.src;
  assign pending_cnt = pending_q;

endmodule
